// File: rtl/csr_reg_pkg.sv
// csr_reg_pkg: CSR address map, write masks and write-resolution helpers for csr_reg.
// The mcycle/mcycleh entries only count as writable when CSR_MCYCLE_EN is defined.
package csr_reg_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [XLEN-1:0] MSTATUS_WMASK = (32'h1 << MSTATUS_MIE) | (32'h1 << MSTATUS_MPIE);
  localparam logic [XLEN-1:0] MSTATUS_FIXED = 32'h0000_1800;
  localparam logic [XLEN-1:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [XLEN-1:0] ALIGN_WMASK   = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [XLEN-1:0] mstatus;
    logic [XLEN-1:0] mie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mip;
  } csr_file_t;

  localparam csr_file_t CSR_FILE_RST = {MSTATUS_FIXED, 192'h0};

  function automatic logic csr_writable(input logic [11:0] addr);
    logic wr;
    case (addr)
      CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE: wr = 1'b1;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE, CSR_MCYCLEH: wr = 1'b1;
`endif
      default: wr = 1'b0;
    endcase
    return wr;
  endfunction

  // Value a write of data to addr actually stores (and what a bypassed read sees).
  function automatic logic [XLEN-1:0] csr_wmask(input logic [11:0] addr, input logic [XLEN-1:0] data);
    logic [XLEN-1:0] val;
    case (addr)
      CSR_MSTATUS:                      val = (data & MSTATUS_WMASK) | MSTATUS_FIXED;
      CSR_MIE:                          val = data & MIE_WMASK;
      CSR_MTVEC, CSR_MEPC:              val = data & ALIGN_WMASK;
      CSR_MSCRATCH, CSR_MCAUSE,
      CSR_MCYCLE, CSR_MCYCLEH:          val = data;
      default:                          val = 32'h0;
    endcase
    return val;
  endfunction

  function automatic csr_file_t csr_apply_wr(input csr_file_t cur, input logic [11:0] addr,
                                             input logic [XLEN-1:0] data);
    csr_file_t nxt;
    nxt = cur;
    case (addr)
      CSR_MSTATUS:  nxt.mstatus  = csr_wmask(addr, data);
      CSR_MIE:      nxt.mie      = csr_wmask(addr, data);
      CSR_MTVEC:    nxt.mtvec    = csr_wmask(addr, data);
      CSR_MSCRATCH: nxt.mscratch = csr_wmask(addr, data);
      CSR_MEPC:     nxt.mepc     = csr_wmask(addr, data);
      CSR_MCAUSE:   nxt.mcause   = csr_wmask(addr, data);
      default:      nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/csr_reg_rd_mux.sv
// csr_rd_mux: combinational CSR read decode with same-cycle write bypass.
// Port b (arbiter) outranks port a (EX) when both write the address being read.
module csr_rd_mux
  import csr_reg_pkg::*;
(
  input  logic [11:0]     rd_addr,
  input  csr_file_t       csr,
  input  logic [63:0]     mcycle,
  input  logic            wr_a_en,
  input  logic [11:0]     wr_a_addr,
  input  logic [XLEN-1:0] wr_a_data,
  input  logic            wr_b_en,
  input  logic [11:0]     wr_b_addr,
  input  logic [XLEN-1:0] wr_b_data,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] csr_val_s;
  logic            hit_a_s;
  logic            hit_b_s;

  assign hit_a_s = wr_a_en && (wr_a_addr == rd_addr) && csr_writable(rd_addr);
  assign hit_b_s = wr_b_en && (wr_b_addr == rd_addr) && csr_writable(rd_addr);

  // Stored-value decode; mcycle is tied to zero by the top when the counter is absent
  always_comb begin
    csr_val_s = 32'h0;
    case (rd_addr)
      CSR_MSTATUS:             csr_val_s = csr.mstatus;
      CSR_MIE:                 csr_val_s = csr.mie;
      CSR_MTVEC:               csr_val_s = csr.mtvec;
      CSR_MSCRATCH:            csr_val_s = csr.mscratch;
      CSR_MEPC:                csr_val_s = csr.mepc;
      CSR_MCAUSE:              csr_val_s = csr.mcause;
      CSR_MIP:                 csr_val_s = csr.mip;
      CSR_MCYCLE, CSR_CYCLE:   csr_val_s = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: csr_val_s = mcycle[63:32];
      default:                 csr_val_s = 32'h0;
    endcase
  end

  // Bypass the masked in-flight write over the stored value
  always_comb begin
    if (hit_b_s) begin
      rd_data = csr_wmask(rd_addr, wr_b_data);
    end else if (hit_a_s) begin
      rd_data = csr_wmask(rd_addr, wr_a_data);
    end else begin
      rd_data = csr_val_s;
    end
  end

endmodule

// File: rtl/csr_reg.sv
// csr_reg: machine-mode CSR file serving the EX stage and the interrupt arbiter.
// Define CSR_MCYCLE_EN to build the 64-bit mcycle counter and its 0xB00/0xB80/0xC00/0xC80 decode.
module csr_reg
  import csr_reg_pkg::*;
#(
  parameter int          DW         = 32,
  parameter int          AW         = 32,
  parameter logic [63:0] MCYCLE_RST = 64'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_wr_en_i,
  input  logic [AW-1:0] ex_wr_addr_i,
  input  logic [DW-1:0] ex_wr_data_i,
  input  logic [AW-1:0] ex_rd_addr_i,
  output logic [DW-1:0] ex_rd_data_o,
  input  logic          clint_wr_en_i,
  input  logic [AW-1:0] clint_wr_addr_i,
  input  logic [DW-1:0] clint_wr_data_i,
  input  logic [AW-1:0] clint_rd_addr_i,
  output logic [DW-1:0] clint_rd_data_o,
  input  logic [2:0]    int_pending_i,
  output logic [DW-1:0] csr_mtvec_o,
  output logic [DW-1:0] csr_mepc_o,
  output logic [DW-1:0] csr_mstatus_o,
  output logic          global_int_en_o
);

  csr_file_t   csr_r;
  csr_file_t   csr_base_s;
  csr_file_t   csr_ex_s;
  csr_file_t   csr_nxt_s;
  logic [63:0] mcycle_s;
  logic [11:0] ex_wa_s;
  logic [11:0] clint_wa_s;
  logic        unused_s;

  assign ex_wa_s    = ex_wr_addr_i[11:0];
  assign clint_wa_s = clint_wr_addr_i[11:0];

  // mip tracks the raw pending lines every cycle; everything else holds by default
  always_comb begin
    csr_base_s     = csr_r;
    csr_base_s.mip = {20'h0, int_pending_i[2], 3'b000, int_pending_i[1], 3'b000,
                      int_pending_i[0], 3'b000};
  end

  // EX applied first so an arbiter write to the same CSR overrides it
  assign csr_ex_s  = ex_wr_en_i    ? csr_apply_wr(csr_base_s, ex_wa_s, ex_wr_data_i)  : csr_base_s;
  assign csr_nxt_s = clint_wr_en_i ? csr_apply_wr(csr_ex_s, clint_wa_s, clint_wr_data_i) : csr_ex_s;

  // CSR state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_r <= CSR_FILE_RST;
    end else begin
      csr_r <= csr_nxt_s;
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [63:0] mcycle_r;
  logic [63:0] mc_base_s;
  logic [63:0] mc_ex_s;
  logic [63:0] mc_nxt_s;
  logic        ex_lo_s;
  logic        ex_hi_s;
  logic        cl_lo_s;
  logic        cl_hi_s;

  assign ex_lo_s = ex_wr_en_i    && (ex_wa_s    == CSR_MCYCLE);
  assign ex_hi_s = ex_wr_en_i    && (ex_wa_s    == CSR_MCYCLEH);
  assign cl_lo_s = clint_wr_en_i && (clint_wa_s == CSR_MCYCLE);
  assign cl_hi_s = clint_wr_en_i && (clint_wa_s == CSR_MCYCLEH);

  // Any half-write suppresses the increment, so the untouched half holds without carry
  assign mc_base_s = (ex_lo_s || ex_hi_s || cl_lo_s || cl_hi_s) ? mcycle_r : mcycle_r + 64'd1;
  assign mc_ex_s   = {ex_hi_s ? ex_wr_data_i : mc_base_s[63:32],
                      ex_lo_s ? ex_wr_data_i : mc_base_s[31:0]};
  assign mc_nxt_s  = {cl_hi_s ? clint_wr_data_i : mc_ex_s[63:32],
                      cl_lo_s ? clint_wr_data_i : mc_ex_s[31:0]};

  // Free-running cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcycle_r <= MCYCLE_RST;
    end else begin
      mcycle_r <= mc_nxt_s;
    end
  end

  assign mcycle_s = mcycle_r;
  assign unused_s = ^{ex_wr_addr_i[AW-1:12], clint_wr_addr_i[AW-1:12],
                      ex_rd_addr_i[AW-1:12], clint_rd_addr_i[AW-1:12]};
`else
  assign mcycle_s = 64'h0;
  assign unused_s = ^{ex_wr_addr_i[AW-1:12], clint_wr_addr_i[AW-1:12],
                      ex_rd_addr_i[AW-1:12], clint_rd_addr_i[AW-1:12], MCYCLE_RST};
`endif

  csr_rd_mux u_ex_rd (
    .rd_addr   (ex_rd_addr_i[11:0]),
    .csr       (csr_r),
    .mcycle    (mcycle_s),
    .wr_a_en   (ex_wr_en_i),
    .wr_a_addr (ex_wa_s),
    .wr_a_data (ex_wr_data_i),
    .wr_b_en   (clint_wr_en_i),
    .wr_b_addr (clint_wa_s),
    .wr_b_data (clint_wr_data_i),
    .rd_data   (ex_rd_data_o)
  );

  csr_rd_mux u_clint_rd (
    .rd_addr   (clint_rd_addr_i[11:0]),
    .csr       (csr_r),
    .mcycle    (mcycle_s),
    .wr_a_en   (ex_wr_en_i),
    .wr_a_addr (ex_wa_s),
    .wr_a_data (ex_wr_data_i),
    .wr_b_en   (clint_wr_en_i),
    .wr_b_addr (clint_wa_s),
    .wr_b_data (clint_wr_data_i),
    .rd_data   (clint_rd_data_o)
  );

  assign csr_mtvec_o     = csr_r.mtvec;
  assign csr_mepc_o      = csr_r.mepc;
  assign csr_mstatus_o   = csr_r.mstatus;
  assign global_int_en_o = csr_r.mstatus[MSTATUS_MIE];

endmodule
